ldm_stm_sequencer: RTL

- Multi-register transfer engine for LDM/STM (block data transfer) instructions.
- Sits between the datapath and data memory. Walks the 16-bit register list in ascending order.
- Loads: writes memory words into the register file through a write port (A3/WE3/WD3 style). Stores: reads registers through a read port and drives them to memory.
- Register file ignores writes to R15, so loaded R15 values leave on a dedicated PC write port.

---
 rtl/ldm_stm_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ldm_stm_sequencer
// Brief    : LDM/STM block-transfer engine walking a 16-bit register list.
//            Optional misaligned-base abort enabled by macro SEQ_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ldm_stm_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_load,
  input  logic [1:0]        mode,
  input  logic              wback,
  input  logic [3:0]        rn,
  input  logic [ADDR_W-1:0] base,
  input  logic [15:0]       reg_list,
  output logic              busy,
  output logic              done,
  output logic              abort,
  output logic [3:0]        rf_a,
  input  logic [DATA_W-1:0] rf_rd,
  output logic              rf_we,
  output logic [3:0]        rf_a3,
  output logic [DATA_W-1:0] rf_wd,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_wd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_XFER  = 3'd1,
    S_DRAIN = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] c_WORD = ADDR_W'(4);

  state_t              r_state, w_next;
  logic                r_is_load;
  logic                r_do_wb;
  logic                r_abort;
  logic [3:0]          r_rn;
  logic [15:0]         r_list;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_final;
  logic                r_pend;
  logic [3:0]          r_pend_reg;
  logic [DATA_W-1:0]   r_pend_data;

  logic [4:0]          w_n;
  logic [ADDR_W-1:0]   w_base, w_span, w_first, w_final;
  logic [3:0]          w_cur;
  logic                w_last;
  logic                w_misalign;

  assign w_base = {base[ADDR_W-1:2], 2'b00};

`ifdef SEQ_ALIGN_CHECK_EN
  assign w_misalign = (base[1:0] != 2'b00);
`else
  logic w_unused_base_lsb;
  assign w_unused_base_lsb = ^base[1:0];
  assign w_misalign        = 1'b0;
`endif

  always_comb begin
    w_n = '0;
    for (int i = 0; i < 16; i++) w_n = w_n + {4'd0, reg_list[i]};
  end

  always_comb begin
    w_span = ADDR_W'({w_n, 2'b00});
    case (mode)
      2'b00:   w_first = w_base;
      2'b01:   w_first = w_base + c_WORD;
      2'b10:   w_first = w_base - w_span + c_WORD;
      default: w_first = w_base - w_span;
    endcase
    w_final = mode[1] ? (w_base - w_span) : (w_base + w_span);
  end

  // Lowest remaining register; ascending order pairs it with the lowest address.
  always_comb begin
    w_cur = 4'd0;
    for (int i = 15; i >= 0; i--) if (r_list[i]) w_cur = 4'(i);
  end

  assign w_last = ((r_list & (r_list - 16'd1)) == 16'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_is_load   <= 1'b0;
      r_do_wb     <= 1'b0;
      r_abort     <= 1'b0;
      r_rn        <= 4'd0;
      r_list      <= 16'd0;
      r_addr      <= '0;
      r_final     <= '0;
      r_pend      <= 1'b0;
      r_pend_reg  <= 4'd0;
      r_pend_data <= '0;
    end else begin
      r_state <= w_next;
      r_pend  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_load <= is_load;
            r_rn      <= rn;
            r_list    <= reg_list;
            r_addr    <= w_first;
            r_final   <= w_final;
            r_abort   <= w_misalign;
            // A loaded base register overrides the writeback value.
            r_do_wb   <= wback && !(is_load && reg_list[rn]) && (rn != 4'd15);
          end
        end
        S_XFER: begin
          if (mem_ack) begin
            r_list      <= r_list & ~(16'd1 << w_cur);
            r_addr      <= r_addr + c_WORD;
            r_pend      <= r_is_load;
            r_pend_reg  <= w_cur;
            r_pend_data <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    rf_a      = 4'd0;
    rf_we     = 1'b0;
    rf_a3     = 4'd0;
    rf_wd     = '0;
    pc_we     = 1'b0;
    pc_wd     = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    // Captured load data retires one cycle after its ack, overlapping the next request.
    if (r_pend) begin
      if (r_pend_reg == 4'd15) begin
        pc_we = 1'b1;
        pc_wd = {r_pend_data[DATA_W-1:2], 2'b00};
      end else begin
        rf_we = 1'b1;
        rf_a3 = r_pend_reg;
        rf_wd = r_pend_data;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (start) w_next = ((reg_list == 16'd0) || w_misalign) ? S_DONE : S_XFER;
      end
      S_XFER: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_we   = !r_is_load;
        mem_addr = r_addr;
        rf_a     = w_cur;
        if (!r_is_load) mem_wdata = rf_rd;
        if (mem_ack && w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        w_next = r_do_wb ? S_WB : S_DONE;
      end
      S_WB: begin
        busy   = 1'b1;
        rf_we  = 1'b1;
        rf_a3  = r_rn;
        rf_wd  = DATA_W'(r_final);
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        abort  = r_abort;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire
